nibble_serial_subtractor: RTL
=============================

Name: nibble_serial_subtractor

Overview:
Multi-cycle wide subtractor that computes diff = a - b - bin for WIDTH-bit operands. It processes one 4-bit nibble per clock through a 4-bit borrow-lookahead slice, chaining the borrow between nibbles. It is the subtract counterpart to the team's 4-bit carry-lookahead adder and serves area-constrained datapaths. Operands enter and results leave through valid/ready handshakes.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4 (elaboration-time check).
NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 iff unsigned a < b + bin
zero  output  1  diff == 0
ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; zero=0; ovf=0; internal operand regs, nibble counter and borrow reg cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On an edge with in_valid=1, capture a, b and bin, set counter=0, and go to RUN. Inputs are ignored otherwise.
- RUN: in_ready=0 and out_valid=0. Each cycle, the slice takes nibble[counter] of a and b plus the borrow reg. It writes 4 diff bits into diff[4*counter +: 4], updates the borrow reg with the slice borrow-out, and increments the counter.
- After nibble NIB-1, go to DONE and latch bout, zero and ovf.
- Latency: out_valid rises exactly NIB cycles after the accepting edge (4 cycles for WIDTH=16).
- DONE: out_valid=1. diff, bout, zero and ovf are held stable until the handshake. On an edge with out_ready=1, go to IDLE with out_valid=0. out_ready is ignored outside DONE.
- No overlap: a new request is accepted no earlier than the cycle after the DONE handshake. in_ready and out_valid are never both high.
- diff is valid only while out_valid=1. Its content in RUN is partial and is don't-care for checking.
- Slice equations (per bit i, bi = borrow-in to bit i):
  - g_i = ~a_i & b_i
  - p_i = ~(a_i ^ b_i)
  - d_i = a_i ^ b_i ^ bi
  - borrow to bit i+1 = g_i | (p_i & bi)
  - All four internal borrows and the slice borrow-out are flattened lookahead sums of products, not a ripple chain.
- Boundaries:
  - a == b with bin=0 -> diff=0, zero=1, bout=0.
  - a == b with bin=1 -> diff all-ones, bout=1.
  - Any transition counter==NIB-1 -> DONE; the counter never wraps in use.
  - Reset asserted mid-RUN or in DONE -> immediate IDLE with cleared outputs; the in-flight result is lost.
  - in_valid held high during RUN or DONE -> no effect, no second capture.
  - out_ready held high continuously -> DONE lasts exactly one cycle.

Decomposition:
- Shared package sub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - nibble width constant NIB_W=4
- One sub-module: borrow_lookahead_sub4. It is purely combinational: inputs x[3:0], y[3:0], bi; outputs d[3:0], bo. It is instantiated once in the top-level block.
- Top level holds the FSM, counter, operand shift/index logic, borrow reg and result flags.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> after 4 cycles diff=0x1000, bout=0, zero=0, ovf=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0, ovf=0. Also a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, ovf=1, bout=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. Pulse out_ready -> IDLE next cycle, in_ready=1. Back-to-back requests with out_ready=1 -> one result every NIB+2 cycles.
- Reset mid-op: assert rst in the 2nd RUN cycle -> out_valid=0, diff=0, in_ready=1 immediately. A following request a=0x00FF, b=0x000F -> diff=0x00F0, bout=0.
- Random: 1000 transactions with random a, b, bin and random out_ready stalls, WIDTH=16 and WIDTH=4 -> every field matches a reference model, and latency = NIB cycles.

Source files
------------

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//
// Contents:
//   ST_IDLE / ST_RUN / ST_DONE : state encodings of the control FSM
//   NIB_W                      : width of one processed slice (a nibble)
//   state_t                    : enumerated FSM state type built on the encodings
package sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/borrow_lookahead_sub4.sv
// 4-bit borrow-lookahead subtract slice: d = x - y - bi.
//
// Ports:
//   x  [3:0] in  : minuend nibble
//   y  [3:0] in  : subtrahend nibble
//   bi       in  : borrow into bit 0
//   d  [3:0] out : difference nibble
//   bo       out : borrow out of bit 3
//
// A bit generates a borrow when x=0,y=1 and propagates an incoming borrow
// when x==y. Every internal borrow is written as a flat sum of products so
// no borrow depends on the previous one's gate output.
module borrow_lookahead_sub4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] bw;  // borrow into each bit position

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = ~x[gi] & y[gi];
            assign p[gi] = ~(x[gi] ^ y[gi]);
        end
    endgenerate

    assign bw[0] = bi;
    assign bw[1] = g[0]
                 | (p[0] & bi);
    assign bw[2] = g[1]
                 | (p[1] & g[0])
                 | (p[1] & p[0] & bi);
    assign bw[3] = g[2]
                 | (p[2] & g[1])
                 | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & bi);
    assign bo    = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & bi);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_diff
            assign d[gi] = x[gi] ^ y[gi] ^ bw[gi];
        end
    endgenerate

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, one nibble per clock.
//
// Ports:
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready high only when idle)
//   a, b, bin             : minuend, subtrahend, borrow-in
//   out_valid / out_ready : result handshake (out_valid high only when done)
//   diff                  : a - b - bin modulo 2^WIDTH
//   bout                  : final borrow (unsigned a < b + bin)
//   zero                  : diff == 0
//   ovf                   : signed overflow of the subtraction
//
// The operand registers shift right by one nibble per RUN cycle, so the
// slice always reads the low nibble; on the final nibble those low bits hold
// the operand sign bits used for the overflow flag.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic [WIDTH-1:0]  diff_reg, diff_next;
    logic [CW-1:0]     cnt_reg;
    logic              borrow_reg;
    logic              bout_reg, zero_reg, ovf_reg;

    logic [NIB_W-1:0]  slice_d;
    logic              slice_bo;
    logic              last_nib;
    logic              run;

    assign run      = (state_reg == S_RUN);
    assign last_nib = (cnt_reg == CW'(NIB - 1));

    borrow_lookahead_sub4 u_slice (
        .x  (a_reg[NIB_W-1:0]),
        .y  (b_reg[NIB_W-1:0]),
        .bi (borrow_reg),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Only the nibble addressed by the counter takes the slice output.
    genvar gi;
    generate
        for (gi = 0; gi < NIB; gi++) begin : g_diff_nib
            assign diff_next[gi*NIB_W +: NIB_W] =
                (run && cnt_reg == CW'(gi)) ? slice_d : diff_reg[gi*NIB_W +: NIB_W];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_nib) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= bin;
                        cnt_reg    <= '0;
                    end
                end
                S_RUN: begin
                    a_reg      <= a_reg >> NIB_W;
                    b_reg      <= b_reg >> NIB_W;
                    borrow_reg <= slice_bo;
                    diff_reg   <= diff_next;
                    if (last_nib) begin
                        cnt_reg  <= '0;
                        bout_reg <= slice_bo;
                        zero_reg <= (diff_next == '0);
                        // Low nibble bit 3 is the operand MSB on the last nibble.
                        ovf_reg  <= (a_reg[NIB_W-1] != b_reg[NIB_W-1]) &&
                                    (slice_d[NIB_W-1] != a_reg[NIB_W-1]);
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule
